// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and byte-enable helper for the load/store unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} lsu_state_t;

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: be_of = 4'b0001 << off;
      F3_H, F3_HU: be_of = 4'b0011 << {off[1], 1'b0};
      F3_W:        be_of = 4'b1111;
      default:     be_of = 4'b0000;
    endcase
  endfunction
endpackage

// File: rtl/lsu_align.sv
// Size/sign decode: byte enables, store lane replication, load lane extraction.
module lsu_align import lsu_pkg::*; (
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [1:0]  off_al,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] rext,
  output logic        misal,
  output logic        illegal
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    off_al  = off;
    misal   = 1'b0;
    illegal = 1'b0;
    wrep    = wdata;
    case (funct3)
      F3_B, F3_BU: wrep = {4{wdata[7:0]}};
      F3_H, F3_HU: begin
        misal  = off[0];
        off_al = {off[1], 1'b0};
        wrep   = {2{wdata[15:0]}};
      end
      F3_W: begin
        misal  = |off;
        off_al = 2'b00;
      end
      default: illegal = 1'b1;
    endcase
    // unsigned variants have no store form
    if (we && funct3[2]) illegal = 1'b1;
    be = be_of(funct3, off_al);
    b  = rword[{off_al, 3'b000} +: 8];
    h  = off_al[1] ? rword[31:16] : rword[15:0];
    case (funct3)
      F3_B:    rext = {{24{b[7]}}, b};
      F3_BU:   rext = {24'd0, b};
      F3_H:    rext = {{16{h[15]}}, h};
      F3_HU:   rext = {16'd0, h};
      F3_W:    rext = rword;
      default: rext = 32'd0;
    endcase
  end
endmodule

// File: rtl/lsu.sv
// Load/store unit: holds the core while one access runs on a valid/ready memory bus.
// LSU_MISALIGN_TRAP_EN: misaligned accesses are trapped instead of force-aligned.
module lsu import lsu_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              misaligned,
  output logic              err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  lsu_state_t        state;
  logic              we_q, mis_q, err_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wd_q, rdata_q, cnt;

  logic        idle, misal, illegal, bad, tmo;
  logic [2:0]  f3_m;
  logic [1:0]  off_m, off_al;
  logic [3:0]  be;
  logic [31:0] wrep, rext;

  // one decoder serves both request capture (IDLE) and load extraction (RESP)
  assign idle  = (state == IDLE);
  assign f3_m  = idle ? funct3 : f3_q;
  assign off_m = idle ? addr[1:0] : off_q;

  lsu_align u_align (
    .funct3 (f3_m),
    .off    (off_m),
    .we     (we),
    .wdata  (wdata),
    .rword  (bus_rdata),
    .off_al (off_al),
    .be     (be),
    .wrep   (wrep),
    .rext   (rext),
    .misal  (misal),
    .illegal(illegal)
  );

  assign bad = illegal | (TRAP & misal);
  assign tmo = (TIMEOUT > 0) && (cnt + 32'd1 == 32'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      addr_q  <= '0;
      be_q    <= 4'd0;
      wd_q    <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= 32'd0;
    end else begin
      case (state)
        IDLE: if (req) begin
          we_q    <= we;
          f3_q    <= funct3;
          off_q   <= off_al;
          addr_q  <= {addr[ADDR_W-1:2], 2'b00};
          be_q    <= be;
          wd_q    <= wrep;
          rdata_q <= 32'd0;
          err_q   <= 1'b0;
          mis_q   <= bad;
          cnt     <= 32'd0;
          state   <= bad ? DONE : REQ;
        end
        REQ: begin
          cnt <= cnt + 32'd1;
          if (bus_ready) state <= we_q ? DONE : RESP;
          else if (tmo) begin
            err_q <= 1'b1;
            state <= DONE;
          end
        end
        RESP: begin
          cnt <= cnt + 32'd1;
          if (bus_rvalid) begin
            rdata_q <= rext;
            state   <= DONE;
          end else if (tmo) begin
            err_q <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall      = (idle & req) | (state == REQ) | (state == RESP);
  assign done       = (state == DONE);
  assign bus_valid  = (state == REQ);
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wd_q;
  assign rdata      = rdata_q;
  assign misaligned = mis_q;
  assign err        = err_q;
endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: byte-level memory reference model vs. a word-level bus slave.
module tb_lsu;
  logic        clk = 1'b0, reset = 1'b1, req = 1'b0, we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        stall, done, misaligned, err, bus_valid, bus_we;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata), .stall(stall), .done(done), .misaligned(misaligned),
    .err(err), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [31:0] rd;
    bit          mis;
    bit          err;
    bit          hs;
    logic [31:0] baddr;
  } exp_t;

  int          vectors = 0, miscompares = 0;
  exp_t        q[$];
  logic [7:0]  ref_mem[1024];
  logic [31:0] mem[256];

  // slave state
  int          rdly = 0, pdly = 0, vcycles = 0;
  bit          pend = 0, hold_ready = 0, hold_rvalid = 0, saw_hs = 0, pv = 0;
  logic [7:0]  raddr = 8'd0;
  logic [31:0] hs_addr = 32'd0, p0_addr = 32'd0, p0_wd = 32'd0;
  logic [3:0]  p0_be = 4'd0;
  logic [31:0] last_rd = 32'd0;
  bit          last_mis = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // reference: memory as bytes, access semantics straight from the ISA rules
  function automatic exp_t model(bit w, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    exp_t e;
    int n, idx;
    bit ill, mal;
    logic [31:0] ea, v;
    e.rd = 32'd0; e.mis = 0; e.err = 0; e.hs = 0; e.baddr = 32'd0;
    n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ill = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (w && f3[2]);
    mal = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    if (mal) ill = 1;
`else
    if (mal) ill = ill;
`endif
    if (ill) begin
      e.mis = 1;
      return e;
    end
    ea      = a & ~(32'(n) - 32'd1);
    e.hs    = 1;
    e.baddr = ea & ~32'd3;
    v       = 32'd0;
    for (int i = 0; i < n; i++) begin
      idx = int'((ea + 32'(i)) & 32'h3FF);
      if (w) ref_mem[idx] = d[8*i +: 8];
      else   v[8*i +: 8] = ref_mem[idx];
    end
    if (!w) begin
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
      e.rd = v;
    end
    return e;
  endfunction

  task automatic setw(input logic [31:0] a, input logic [31:0] v);
    mem[a[9:2]] = v;
    for (int j = 0; j < 4; j++) ref_mem[int'({a[9:2], 2'b00}) + j] = v[8*j +: 8];
  endtask

  task automatic start(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  // drives inputs, scrambles them while stalled, waits for done
  task automatic issue(input exp_t e, input bit w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, output int lat);
    q.push_back(e);
    vcycles = 0;
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      req = 1'($urandom_range(1)); we = 1'($urandom_range(1));
      funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    end while (!done && lat < 60);
    req = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
  endtask

  // bus slave
  initial begin
    forever begin
      @(negedge clk);
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      if (pend && !hold_rvalid) begin
        if (pdly == 0) begin
          bus_rvalid = 1'b1; bus_rdata = mem[raddr]; pend = 0;
        end else pdly--;
      end
      if (bus_valid) begin
        vcycles++;
        if (!pv) begin
          p0_addr = bus_addr; p0_wd = bus_wdata; p0_be = bus_be; pv = 1;
        end else begin
          chk("stable_addr", bus_addr, p0_addr);
          chk("stable_wdata", bus_wdata, p0_wd);
          chk("stable_be", 32'(bus_be), 32'(p0_be));
        end
        if (!hold_ready) begin
          if (rdly == 0) begin
            bus_ready = 1'b1; saw_hs = 1; hs_addr = bus_addr;
            if (bus_we) begin
              for (int j = 0; j < 4; j++)
                if (bus_be[j]) mem[bus_addr[9:2]][8*j +: 8] = bus_wdata[8*j +: 8];
            end else begin
              pend = 1; pdly = $urandom_range(2); raddr = bus_addr[9:2];
            end
            rdly = $urandom_range(2);
          end else rdly--;
        end
      end else pv = 0;
    end
  end

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else begin
          e = q.pop_front();
          last_rd = rdata; last_mis = misaligned;
          chk("rdata", rdata, e.rd);
          chk("misaligned", 32'(misaligned), 32'(e.mis));
          chk("err", 32'(err), 32'(e.err));
          chk("bus_access", 32'(saw_hs), 32'(e.hs));
          if (e.hs && saw_hs) chk("bus_addr", hs_addr, e.baddr);
        end
        saw_hs = 0;
      end
    end
  end

  initial begin
    int lat, n;
    exp_t e;
    bit w;
    logic [2:0] f3;
    logic [31:0] a, d;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      for (int j = 0; j < 4; j++) ref_mem[4*i + j] = mem[i][8*j +: 8];
    end
    @(negedge clk); @(negedge clk);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;

    rdly = 0;
    issue(model(1, 3'b010, 32'h100, 32'hDEADBEEF), 1, 3'b010, 32'h100, 32'hDEADBEEF, lat);
    chk("sw_latency", 32'(lat), 32'd2);
    chk("sw_be", 32'(p0_be), 32'hF);
    chk("sw_wdata", p0_wd, 32'hDEADBEEF);

    setw(32'h200, 32'h80FFFFFF);
    rdly = 0;
    issue(model(0, 3'b000, 32'h203, 0), 0, 3'b000, 32'h203, 32'd0, lat);
    chk("lb_be", 32'(p0_be), 32'h8);
    chk("lb_rdata", last_rd, 32'hFFFFFF80);
    issue(model(0, 3'b100, 32'h203, 0), 0, 3'b100, 32'h203, 32'd0, lat);
    chk("lbu_rdata", last_rd, 32'h00000080);

    rdly = 3;
    issue(model(1, 3'b001, 32'h302, 32'h1234ABCD), 1, 3'b001, 32'h302, 32'h1234ABCD, lat);
    chk("sh_wdata", p0_wd, 32'hABCDABCD);
    chk("sh_be", 32'(p0_be), 32'hC);
    chk("sh_valid_cycles", 32'(vcycles), 32'd4);

    setw(32'h400, 32'hCAFEF00D);
    issue(model(0, 3'b010, 32'h401, 0), 0, 3'b010, 32'h401, 32'd0, lat);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_nobus", 32'(vcycles), 32'd0);
    chk("lw_mis_flag", 32'(last_mis), 32'd1);
`else
    chk("lw_forced_rdata", last_rd, 32'hCAFEF00D);
`endif
    issue(model(0, 3'b011, 32'h500, 0), 0, 3'b011, 32'h500, 32'd0, lat);
    chk("illegal_nobus", 32'(vcycles), 32'd0);
    chk("illegal_flag", 32'(last_mis), 32'd1);

    for (int k = 0; k < 300; k++) begin
      w = 1'($urandom_range(1)); f3 = 3'($urandom); a = $urandom; d = $urandom;
      issue(model(w, f3, a, d), w, f3, a, d, lat);
    end

    // watchdog on a stuck request and on a missing response
    hold_ready = 1;
    e.rd = 32'd0; e.mis = 0; e.err = 1; e.hs = 0; e.baddr = 32'd0;
    issue(e, 1, 3'b010, 32'h600, 32'h11111111, lat);
    chk("tmo_req_cycles", 32'(vcycles), 32'd8);
    chk("tmo_req_latency", 32'(lat), 32'd9);
    hold_ready = 0; hold_rvalid = 1; rdly = 0;
    e.hs = 1; e.baddr = 32'h700;
    issue(e, 0, 3'b010, 32'h700, 32'd0, lat);
    chk("tmo_resp_latency", 32'(lat), 32'd9);
    pend = 0; hold_rvalid = 0;

    // reset during REQ drops bus_valid without waiting for a clock
    hold_ready = 1;
    start(1, 3'b010, 32'h800, 32'h22222222);
    chk("req_valid_before_rst", 32'(bus_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_async_valid", 32'(bus_valid), 32'd0);
    chk("rst_async_stall", 32'(stall), 32'd0);
    @(negedge clk); reset = 1'b0; hold_ready = 0;

    // reset during RESP; the late rvalid must not produce a completion
    hold_rvalid = 1; rdly = 0;
    start(0, 3'b010, 32'h900, 32'd0);
    n = 0;
    while (!(stall && !bus_valid) && n < 10) begin @(negedge clk); n++; end
    chk("reached_resp", 32'(stall && !bus_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(bus_valid), 32'd0);
    chk("rst_resp_done", 32'(done), 32'd0);
    @(negedge clk); reset = 1'b0; hold_rvalid = 0; saw_hs = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("late_rvalid_ignored", 32'(done | stall), 32'd0);
    end
    saw_hs = 0;

    rdly = 0;
    issue(model(0, 3'b101, 32'h202, 0), 0, 3'b101, 32'h202, 32'd0, lat);
    @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
